sim_run_controller: RTL
=======================

// Module: sim_run_controller
// PURPOSE
// - Parametrised run controller for CPU simulation: sequences CPU reset, counts cycles,
//   and ends the run on a signature-store, a PC self-loop (halt), or a cycle budget.
// - Sits between the bench clock/reset source and the CPU top.
// - Replaces fixed toggle-count run loops; the bench waits on `done` and reads `pass`/`status`.
// PARAMETERS
// - RST_CYCLES   4            cycles cpu_reset is held after reset release or restart (>=1)
// - MAX_CYCLES   1500         RUN-cycle budget before TIMEOUT (>=1)
// - CNT_W        32           width of cycle_count/retire_count
// - PC_W         32           PC / address / data width
// - LOOP_LIMIT   8            consecutive cycles of unchanged pc_in => HALT (>=2)
// - DONE_ADDR    32'h000000FC signature store address
// - PASS_VAL     32'h1        signature value meaning pass
// PORTS
// - clk           in   1      clock, rising-edge
// - reset         in   1      asynchronous, active-high
// - restart       in   1      synchronous re-run request; returns to HOLD from any state
// - pc_in         in   PC_W   CPU fetch PC
// - mem_we        in   1      CPU data-memory write strobe
// - mem_addr      in   PC_W   CPU data-memory address
// - mem_wdata     in   PC_W   CPU data-memory write data
// - cpu_reset     out  1      reset driven to CPU, high in HOLD
// - cycle_count   out  CNT_W  cycles spent in RUN, frozen once done
// - done          out  1      run finished (sticky until reset/restart)
// - pass          out  1      signature matched PASS_VAL; valid when done
// - status        out  3      0 HOLD, 1 RUN, 2 PASS, 3 FAIL, 4 HALT, 5 TIMEOUT
// BEHAVIOUR
// - Reset (async): state=HOLD, cpu_reset=1, hold counter=0, cycle_count=0, done=0, pass=0,
//   loop counter=0, last_pc=0, status=0.
// - HOLD: cpu_reset=1; counter increments each cycle. On the cycle it reaches RST_CYCLES-1,
//   next state=RUN. So cpu_reset is high exactly RST_CYCLES cycles after reset falls.
// - RUN: cpu_reset=0; cycle_count increments by 1 every cycle and saturates at 2^CNT_W-1.
// - RUN checks are evaluated each cycle from the current-cycle inputs, with this priority:
//   - 1) Signature: mem_we && mem_addr==DONE_ADDR. Next state PASS if mem_wdata==PASS_VAL,
//     else FAIL.
//   - 2) Halt: pc_in==last_pc increments the loop counter, otherwise it clears it. When the
//     counter reaches LOOP_LIMIT-1 on a match, next state=HALT. Stall bubbles shorter than
//     LOOP_LIMIT never halt.
//   - 3) Timeout: cycle_count==MAX_CYCLES-1 next state=TIMEOUT.
//   - Simultaneous events resolve by this priority; exactly one terminal state is entered.
// - last_pc is registered every RUN cycle; it is cleared in HOLD.
// - Terminal states (PASS/FAIL/HALT/TIMEOUT):
//   - done=1 from the first cycle in the state; pass=1 only in PASS.
//   - cpu_reset=0, so the CPU keeps running for waveform inspection.
//   - All counters and outputs frozen. Further inputs ignored; the states are absorbing.
// - restart (synchronous, any state incl. mid-RUN or mid-HOLD): next cycle state=HOLD, all
//   counters, done and pass cleared, cpu_reset=1. restart has priority over all RUN checks.
// - Async reset asserted mid-run: immediate return to the reset values above.
// - All outputs registered; no combinational path from inputs to outputs.
// - Latency: a signature store seen at edge N gives done=1 after edge N.
// STRUCTURE
// - Shared package/header `sim_ctrl_defs`: status encodings (ST_HOLD..ST_TIMEOUT, 3 bits).
//   The bench decodes status with the same constants.
// - One sub-module, `pc_loop_detector`: last_pc register plus saturating match counter,
//   outputs `loop_hit`, with a clear input driven in HOLD/restart.
// - Top: state register, hold counter, cycle counter, priority next-state logic.
// TESTING
// - Reset release, RST_CYCLES=4 -> cpu_reset high 4 cycles, status 0->1, cycle_count=0 on
//   the first RUN cycle.
// - Store 0x1 to 0xFC at RUN cycle 20 -> done=1, pass=1, status=2, cycle_count frozen at 20.
//   Same with data 0x5 -> status=3, pass=0.
// - pc_in held at 0x40 for 8 cycles -> status=4. Held 7 cycles then changed -> no halt.
// - No events, MAX_CYCLES=50 -> status=5 after 50 RUN cycles, done=1.
//   Signature on the same cycle as budget expiry -> status=2.
// - restart at RUN cycle 10 -> HOLD next cycle, counters 0, cpu_reset high 4 cycles, rerun ok.
//   Async reset mid-HOLD -> immediate reset values.

Source files
------------

// File: rtl/sim_ctrl_defs.sv
// Shared definitions for the simulation run controller: status encodings and FSM states.
package sim_ctrl_defs;

  localparam logic [2:0] ST_HOLD    = 3'd0;
  localparam logic [2:0] ST_RUN     = 3'd1;
  localparam logic [2:0] ST_PASS    = 3'd2;
  localparam logic [2:0] ST_FAIL    = 3'd3;
  localparam logic [2:0] ST_HALT    = 3'd4;
  localparam logic [2:0] ST_TIMEOUT = 3'd5;

  // State values equal the status encodings so status is a straight copy of the state.
  typedef enum logic [2:0] {
    StHold    = ST_HOLD,
    StRun     = ST_RUN,
    StPass    = ST_PASS,
    StFail    = ST_FAIL,
    StHalt    = ST_HALT,
    StTimeout = ST_TIMEOUT
  } run_state_e;

  function automatic logic is_terminal(run_state_e s);
    return (s == StPass) || (s == StFail) || (s == StHalt) || (s == StTimeout);
  endfunction

endpackage

// File: rtl/pc_loop_detector.sv
// Detects a CPU stuck on one PC: counts consecutive cycles where pc_in equals the last PC.
module pc_loop_detector #(
  parameter int unsigned PC_W       = 32,
  parameter int unsigned LOOP_LIMIT = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            enable,
  input  logic [PC_W-1:0] pc_in,
  output logic            loop_hit
);

  localparam int unsigned CntW = ($clog2(LOOP_LIMIT) > 0) ? $clog2(LOOP_LIMIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(LOOP_LIMIT - 1);
  localparam logic [CntW-1:0] CntPreHit = CntW'(LOOP_LIMIT - 2);

  logic [PC_W-1:0] last_pc_q;
  logic [CntW-1:0] match_cnt_q;
  logic            match;

  assign match = (pc_in == last_pc_q);

  // Fires on the match that takes the counter to LOOP_LIMIT-1.
  assign loop_hit = enable && match && (match_cnt_q == CntPreHit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_pc_q   <= '0;
      match_cnt_q <= '0;
    end else if (clear) begin
      last_pc_q   <= '0;
      match_cnt_q <= '0;
    end else if (enable) begin
      last_pc_q <= pc_in;
      if (!match) begin
        match_cnt_q <= '0;
      end else if (match_cnt_q != CntMax) begin
        match_cnt_q <= match_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sim_run_controller.sv
// Run controller for CPU simulation: holds CPU reset, counts RUN cycles and ends the run on
// a signature store, a PC self-loop or an exhausted cycle budget.
module sim_run_controller
  import sim_ctrl_defs::*;
#(
  parameter int unsigned     RST_CYCLES = 4,
  parameter int unsigned     MAX_CYCLES = 1500,
  parameter int unsigned     CNT_W      = 32,
  parameter int unsigned     PC_W       = 32,
  parameter int unsigned     LOOP_LIMIT = 8,
  parameter logic [PC_W-1:0] DONE_ADDR  = 32'h0000_00FC,
  parameter logic [PC_W-1:0] PASS_VAL   = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic [PC_W-1:0]  pc_in,
  input  logic             mem_we,
  input  logic [PC_W-1:0]  mem_addr,
  input  logic [PC_W-1:0]  mem_wdata,
  output logic             cpu_reset,
  output logic [CNT_W-1:0] cycle_count,
  output logic             done,
  output logic             pass,
  output logic [2:0]       status
);

  localparam int unsigned HoldW = ($clog2(RST_CYCLES) > 0) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] BudgetLast = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntSat = {CNT_W{1'b1}};

  run_state_e       state_q, state_d;
  logic [HoldW-1:0] hold_cnt_q;
  logic             sig_hit, sig_pass, budget_hit, loop_hit;
  logic             loop_clear, loop_en;

  assign loop_clear = restart || (state_q == StHold);
  assign loop_en    = (state_q == StRun);

  pc_loop_detector #(
    .PC_W       (PC_W),
    .LOOP_LIMIT (LOOP_LIMIT)
  ) u_loop_det (
    .clk      (clk),
    .reset    (reset),
    .clear    (loop_clear),
    .enable   (loop_en),
    .pc_in    (pc_in),
    .loop_hit (loop_hit)
  );

  always_comb begin
    sig_hit    = mem_we && (mem_addr == DONE_ADDR);
    sig_pass   = (mem_wdata == PASS_VAL);
    budget_hit = (cycle_count == BudgetLast);
    state_d    = state_q;
    if (restart) begin
      state_d = StHold;
    end else begin
      unique case (state_q)
        StHold: begin
          if (hold_cnt_q == HoldLast) state_d = StRun;
        end
        StRun: begin
          // Signature beats halt beats timeout when they coincide.
          if (sig_hit) begin
            state_d = sig_pass ? StPass : StFail;
          end else if (loop_hit) begin
            state_d = StHalt;
          end else if (budget_hit) begin
            state_d = StTimeout;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StHold;
      hold_cnt_q  <= '0;
      cycle_count <= '0;
      cpu_reset   <= 1'b1;
      done        <= 1'b0;
      pass        <= 1'b0;
      status      <= ST_HOLD;
    end else begin
      state_q   <= state_d;
      status    <= 3'(state_d);
      cpu_reset <= (state_d == StHold);
      done      <= is_terminal(state_d);
      pass      <= (state_d == StPass);
      if (restart) begin
        hold_cnt_q  <= '0;
        cycle_count <= '0;
      end else if (state_q == StHold) begin
        if (hold_cnt_q != HoldLast) hold_cnt_q <= hold_cnt_q + 1'b1;
      end else if (state_q == StRun) begin
        if (cycle_count != CntSat) cycle_count <= cycle_count + 1'b1;
      end
    end
  end

endmodule
